// File: rtl/fano_pkg.sv
// Shared types and limits for the Fano front-end phase scheduler.
package fano_pkg;

  localparam int N_PHASE_MAX = 8;
  localparam int PH_W_MAX    = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLUSH  = 2'd1,
    SEARCH = 2'd2,
    LOCKED = 2'd3
  } sched_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear (priority) that holds at all-ones.
// Count visible the cycle after i_inc; no backpressure.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/fano_phase_sched.sv
// Steps phase/IQ-swap hypotheses, flushing the LLR path after each change, and qualifies lock.
// All outputs registered: request at edge N shows at N+1; no backpressure, requests outside SEARCH are dropped.
module fano_phase_sched
  import fano_pkg::*;
#(
  parameter int N_PHASE  = N_PHASE_MAX,
  parameter int PH_W     = PH_W_MAX,
  parameter int SETTLE_W = 8,
  parameter int LOCK_W   = 16,
  parameter int SWEEP_W  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_enable,
  input  logic [PH_W:0]       i_phase_count,
  input  logic [SETTLE_W-1:0] i_settle_len,
  input  logic [LOCK_W-1:0]   i_lock_cycles,
  input  logic                i_next_phase,
  input  logic                i_is_sync,
  output logic [PH_W-1:0]     o_phase,
  output logic                o_flush,
  output logic                o_last_phase_stb,
  output logic                o_locked,
  output logic                o_lock_lost_stb,
  output logic [SWEEP_W-1:0]  o_sweep_cnt
);

  localparam logic [PH_W:0] LP_NPH = N_PHASE[PH_W:0];

  sched_state_t        r_state;
  logic [SETTLE_W-1:0] r_settle;
  logic [PH_W-1:0]     r_phase;
  logic                r_flush;
  logic                r_last_stb;
  logic                r_locked;
  logic                r_lost_stb;

  logic [PH_W:0]       w_pc_eff;
  logic [PH_W:0]       w_last_idx;
  logic                w_wrap;
  logic                w_step;
  logic [LOCK_W-1:0]   w_lock_eff;
  logic [LOCK_W-1:0]   w_sync_cnt;
  logic                w_lock_hit;
  logic                w_sync_clr;
  logic                w_sync_inc;
  logic                w_sweep_clr;

  // Out-of-range hypothesis counts fall back to the full set.
  assign w_pc_eff   = ((i_phase_count == '0) || (i_phase_count > LP_NPH)) ? LP_NPH : i_phase_count;
  assign w_last_idx = w_pc_eff - 1'b1;
  assign w_step     = i_enable && (r_state == SEARCH) && i_next_phase;
  assign w_wrap     = w_step && ({1'b0, r_phase} == w_last_idx);

  assign w_lock_eff = (i_lock_cycles == '0) ? LOCK_W'(1) : i_lock_cycles;
  // True when this cycle's sync sample completes the qualification run.
  assign w_lock_hit = i_is_sync && (w_sync_cnt >= (w_lock_eff - 1'b1));

  assign w_sync_clr  = !i_enable || (r_state != SEARCH) || !i_is_sync || i_next_phase;
  assign w_sync_inc  = i_is_sync;
  assign w_sweep_clr = !i_enable || (r_state == IDLE);

  sat_counter #(.W(LOCK_W)) u_sync_cnt (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_sync_clr),
    .i_inc (w_sync_inc),
    .o_cnt (w_sync_cnt)
  );

  sat_counter #(.W(SWEEP_W)) u_sweep_cnt (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_sweep_clr),
    .i_inc (w_wrap),
    .o_cnt (o_sweep_cnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_settle   <= '0;
      r_phase    <= '0;
      r_flush    <= 1'b0;
      r_last_stb <= 1'b0;
      r_locked   <= 1'b0;
      r_lost_stb <= 1'b0;
    end else begin
      r_last_stb <= 1'b0;
      r_lost_stb <= 1'b0;
      if (!i_enable) begin
        r_state  <= IDLE;
        r_settle <= '0;
        r_phase  <= '0;
        r_flush  <= 1'b0;
        r_locked <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state  <= FLUSH;
            r_settle <= i_settle_len;
            r_flush  <= 1'b1;
          end
          FLUSH: begin
            if (r_settle == '0) begin
              r_state <= SEARCH;
              r_flush <= 1'b0;
            end else begin
              r_settle <= r_settle - 1'b1;
            end
          end
          SEARCH: begin
            if (i_next_phase) begin
              r_phase    <= w_wrap ? '0 : r_phase + 1'b1;
              r_last_stb <= w_wrap;
              r_state    <= FLUSH;
              r_settle   <= i_settle_len;
              r_flush    <= 1'b1;
            end else if (w_lock_hit) begin
              r_state  <= LOCKED;
              r_locked <= 1'b1;
            end
          end
          LOCKED: begin
            if (!i_is_sync) begin
              r_state    <= SEARCH;
              r_locked   <= 1'b0;
              r_lost_stb <= 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign o_phase          = r_phase;
  assign o_flush          = r_flush;
  assign o_last_phase_stb = r_last_stb;
  assign o_locked         = r_locked;
  assign o_lock_lost_stb  = r_lost_stb;

endmodule

// File: tb/tb_fano_phase_sched.sv
// Scoreboard bench for fano_phase_sched: expectations queued with each stimulus, checked after the edge.
module tb_fano_phase_sched;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       i_enable = 1'b0;
  logic [3:0] i_phase_count = 4'd4;
  logic [7:0] i_settle_len = 8'd3;
  logic [15:0] i_lock_cycles = 16'd10;
  logic       i_next_phase = 1'b0;
  logic       i_is_sync = 1'b0;
  logic [2:0] o_phase;
  logic       o_flush;
  logic       o_last_phase_stb;
  logic       o_locked;
  logic       o_lock_lost_stb;
  logic [7:0] o_sweep_cnt;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  fano_phase_sched dut (
    .clk              (clk),
    .reset            (reset),
    .i_enable         (i_enable),
    .i_phase_count    (i_phase_count),
    .i_settle_len     (i_settle_len),
    .i_lock_cycles    (i_lock_cycles),
    .i_next_phase     (i_next_phase),
    .i_is_sync        (i_is_sync),
    .o_phase          (o_phase),
    .o_flush          (o_flush),
    .o_last_phase_stb (o_last_phase_stb),
    .o_locked         (o_locked),
    .o_lock_lost_stb  (o_lock_lost_stb),
    .o_sweep_cnt      (o_sweep_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      0:       return {29'd0, o_phase};
      1:       return {31'd0, o_flush};
      2:       return {31'd0, o_last_phase_stb};
      3:       return {31'd0, o_locked};
      4:       return {31'd0, o_lock_lost_stb};
      default: return {24'd0, o_sweep_cnt};
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input int val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic exp_all(input string tag, input int ph, input int fl, input int last,
                         input int lk, input int lost, input int sw);
    push({tag, ".phase"}, 0, ph);
    push({tag, ".flush"}, 1, fl);
    push({tag, ".last"},  2, last);
    push({tag, ".locked"}, 3, lk);
    push({tag, ".lost"},  4, lost);
    push({tag, ".sweep"}, 5, sw);
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk(e.tag, observe(e.sel), e.val);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    drain();
  endtask

  initial begin
    int sw;
    #2 reset = 1'b1;
    #1;
    exp_all("rst", 0, 0, 0, 0, 0, 0);
    drain();
    repeat (2) cyc();
    reset = 1'b0;
    cyc();

    // Enable: four flush cycles, then SEARCH at phase 0.
    i_enable = 1'b1;
    repeat (4) begin
      exp_all("en_flush", 0, 1, 0, 0, 0, 0);
      cyc();
    end
    exp_all("en_search", 0, 0, 0, 0, 0, 0);
    cyc();

    // Four steps through a 4-hypothesis set.
    sw = 0;
    for (int p = 1; p <= 4; p++) begin
      if (p == 4) sw = 1;
      i_next_phase = 1'b1;
      exp_all("step", p % 4, 1, (p == 4) ? 1 : 0, 0, 0, sw);
      cyc();
      i_next_phase = 1'b0;
      repeat (3) begin
        exp_all("step_flush", p % 4, 1, 0, 0, 0, sw);
        cyc();
      end
      exp_all("step_done", p % 4, 0, 0, 0, 0, sw);
      cyc();
    end

    // Nine-cycle sync burst then a drop: no lock.
    i_is_sync = 1'b1;
    repeat (9) begin
      exp_all("burst9", 0, 0, 0, 0, 0, 1);
      cyc();
    end
    i_is_sync = 1'b0;
    exp_all("burst_drop", 0, 0, 0, 0, 0, 1);
    cyc();

    // Held sync: lock after exactly ten samples.
    i_is_sync = 1'b1;
    repeat (9) begin
      exp_all("qual", 0, 0, 0, 0, 0, 1);
      cyc();
    end
    exp_all("lock", 0, 0, 0, 1, 0, 1);
    cyc();

    // Next-phase ignored while locked, then loss of lock.
    i_next_phase = 1'b1;
    exp_all("lock_next", 0, 0, 0, 1, 0, 1);
    cyc();
    i_next_phase = 1'b0;
    i_is_sync = 1'b0;
    exp_all("lost", 0, 0, 0, 0, 1, 1);
    cyc();
    exp_all("lost_after", 0, 0, 0, 0, 0, 1);
    cyc();

    // Step and lock qualification collide: step wins.
    i_is_sync = 1'b1;
    repeat (9) begin
      exp_all("pre_coll", 0, 0, 0, 0, 0, 1);
      cyc();
    end
    i_next_phase = 1'b1;
    exp_all("collide", 1, 1, 0, 0, 0, 1);
    cyc();
    i_is_sync = 1'b0;
    exp_all("flush_nextreq", 1, 1, 0, 0, 0, 1);
    cyc();
    i_next_phase = 1'b0;
    repeat (2) begin
      exp_all("flush_ign", 1, 1, 0, 0, 0, 1);
      cyc();
    end
    exp_all("flush_end", 1, 0, 0, 0, 0, 1);
    cyc();

    // Disable returns to IDLE and clears phase and sweeps.
    i_enable = 1'b0;
    exp_all("disable", 0, 0, 0, 0, 0, 0);
    cyc();

    // Phase count 0 means the full eight-hypothesis set.
    i_phase_count = 4'd0;
    i_settle_len = 8'd0;
    i_enable = 1'b1;
    exp_all("pc0_flush", 0, 1, 0, 0, 0, 0);
    cyc();
    exp_all("pc0_search", 0, 0, 0, 0, 0, 0);
    cyc();
    for (int p = 1; p <= 8; p++) begin
      i_next_phase = 1'b1;
      exp_all("pc0_step", p % 8, 1, (p == 8) ? 1 : 0, 0, 0, (p == 8) ? 1 : 0);
      cyc();
      i_next_phase = 1'b0;
      exp_all("pc0_settle", p % 8, 0, 0, 0, 0, (p == 8) ? 1 : 0);
      cyc();
    end

    // Sweep counter saturation with a single-hypothesis set.
    i_enable = 1'b0;
    cyc();
    i_phase_count = 4'd1;
    i_enable = 1'b1;
    cyc();
    cyc();
    for (int k = 1; k <= 300; k++) begin
      i_next_phase = 1'b1;
      push("sat_last", 2, 1);
      push("sat_sweep", 5, (k > 255) ? 255 : k);
      cyc();
      i_next_phase = 1'b0;
      cyc();
    end
    push("sat_phase", 0, 0);
    cyc();

    // Asynchronous reset in the middle of a flush.
    i_enable = 1'b0;
    cyc();
    i_settle_len = 8'd5;
    i_phase_count = 4'd4;
    i_enable = 1'b1;
    cyc();
    exp_all("pre_rst_flush", 0, 1, 0, 0, 0, 0);
    cyc();
    reset = 1'b1;
    #1;
    exp_all("rst_mid_flush", 0, 0, 0, 0, 0, 0);
    drain();
    exp_all("rst_hold", 0, 0, 0, 0, 0, 0);
    cyc();
    i_enable = 1'b0;
    reset = 1'b0;
    exp_all("rst_release", 0, 0, 0, 0, 0, 0);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fano_phase_sched.md
# fano_phase_sched

Phase-hypothesis scheduler for the Fano decoder front end. Consumes the decoder's "try next phase" request and sync flag. Steps a phase/IQ-swap hypothesis index through the configured set, flushing the LLR path after every change. Declares lock after sync has held for a programmable time and reports sweep wrap-around and loss of lock to the decoder and control logic.

## Interface
Parameters:
- N_PHASE, 8, maximum number of hypotheses (4 rotations × IQ swap)
- PH_W, 3, width of the phase index, clog2(N_PHASE)
- SETTLE_W, 8, width of the flush-length setting
- LOCK_W, 16, width of the lock-qualification counter
- SWEEP_W, 8, width of the saturating sweep counter

Ports:
- clk  in  1  single clock
- reset  in  1  asynchronous, active-high; all state cleared
- i_enable  in  1  level; 0 forces IDLE
- i_phase_count  in  PH_W+1  hypotheses in use; 0 or >N_PHASE treated as N_PHASE
- i_settle_len  in  SETTLE_W  flush length minus one, sampled on FLUSH entry
- i_lock_cycles  in  LOCK_W  consecutive i_is_sync cycles required for lock
- i_next_phase  in  1  single-cycle request from decoder
- i_is_sync  in  1  decoder sync level
- o_phase  out  PH_W  current hypothesis index; reset 0
- o_flush  out  1  LLR/decoder flush (drives the decoder's llr-reset path); reset 0
- o_last_phase_stb  out  1  1-cycle pulse on wrap to index 0; reset 0
- o_locked  out  1  lock level; reset 0
- o_lock_lost_stb  out  1  1-cycle pulse on LOCKED→SEARCH; reset 0
- o_sweep_cnt  out  SWEEP_W  completed sweeps, saturating; reset 0

## Operation
- FSM states: IDLE, FLUSH, SEARCH, LOCKED. Reset state is IDLE.
- IDLE:
  - Outputs: o_phase=0, o_flush=0, o_locked=0, o_sweep_cnt=0.
  - i_enable=1 → FLUSH; load settle counter from i_settle_len.
- FLUSH:
  - o_flush=1.
  - Settle counter decrements each cycle. At 0 → SEARCH, so flush lasts i_settle_len+1 cycles.
  - i_next_phase and i_is_sync are ignored.
- SEARCH:
  - Sync counter counts consecutive cycles with i_is_sync=1 and clears when i_is_sync=0.
  - Sync counter reaches i_lock_cycles → LOCKED. i_lock_cycles=0 behaves as 1.
  - On i_next_phase:
    - Advance o_phase; index i_phase_count-1 wraps to 0.
    - On wrap, pulse o_last_phase_stb and increment o_sweep_cnt, saturating at all-ones.
    - Clear the sync counter and go to FLUSH.
  - i_next_phase takes priority over lock qualification in the same cycle.
- LOCKED:
  - o_locked=1; i_next_phase is ignored.
  - i_is_sync=0 → pulse o_lock_lost_stb, clear o_locked, go to SEARCH with o_phase unchanged.
- i_enable=0 in any state → IDLE next cycle. This returns o_phase to 0 and clears counters. It overrides all other transitions.
- Asynchronous reset mid-flush or mid-lock clears everything immediately, with no strobes emitted.
- Static configuration inputs may change only while i_enable=0. i_settle_len is the exception: it is re-sampled on each FLUSH entry.

## Timing
- All outputs are registered, with no combinational input→output paths.
- i_next_phase sampled at edge N:
  - o_phase updates at N+1.
  - o_flush rises at N+1.
  - o_last_phase_stb, if wrapping, is high only at N+1.
- o_flush is high for exactly i_settle_len+1 cycles. First SEARCH cycle follows immediately.
- Lock timing: i_is_sync high from cycle S onward, in SEARCH → o_locked=1 at S+i_lock_cycles.
- Loss of lock: i_is_sync low at edge L → o_locked=0 and o_lock_lost_stb=1 at L+1.
- Enable: i_enable rising at edge E → o_flush=1 at E+1.

## Structure
- Shared package fano_pkg holds:
  - the state enum sched_state_t (IDLE, FLUSH, SEARCH, LOCKED);
  - the constants N_PHASE_MAX=8 and PH_W_MAX=3.
- One sub-module, sat_counter, provides the generic up-counter with clear and saturate. It is used for the sync counter and o_sweep_cnt.
- The settle counter is a plain down-counter kept inline.

## Test plan
- Enable with i_settle_len=3, i_phase_count=4 → o_flush high 4 cycles, then SEARCH with o_phase=0.
- Pulse i_next_phase 4 times, each after the flush ends → o_phase 1,2,3,0:
  - o_last_phase_stb once, on the 3→0 step;
  - o_sweep_cnt=1;
  - each step followed by a 4-cycle flush.
- i_lock_cycles=10, i_is_sync held high → o_locked rises exactly 10 cycles later. A 9-cycle burst followed by a 1-cycle drop → no lock.
- In LOCKED, deassert i_is_sync → o_lock_lost_stb single pulse, o_locked=0, o_phase unchanged; i_next_phase during LOCKED is ignored.
- i_next_phase and lock qualification in the same cycle → phase advances, no lock. i_next_phase during FLUSH → ignored.
- i_phase_count=0 → wrap after index 7. Force 300 sweeps → o_sweep_cnt=255. Assert reset mid-flush → all outputs 0 with no strobe. Drop i_enable → IDLE and o_phase=0.
